hack_keyboard: RTL and testbench

PS/2 set-2 keyboard decoder producing the Hack `KBD` register value. It consumes raw scan bytes from the PS/2 receiver and tracks make, break and E0-extended sequences, shift and caps lock. It keeps a parametrised stack of held keys so the most recently pressed still-held key is always presented. It supersedes the single-key `ascii` translator and feeds the memory-mapped keyboard register.

---
 rtl/hack_keyboard.sv | 246 ++++++++++++++++++++++++
 tb/tb_hack_keyboard.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_keyboard.sv
// PS/2 set-2 scan decoder for the Hack KBD register: prefix FSM, shift/caps
// tracking and a stack of held keys whose top entry is presented on key.
module hack_keyboard #(
  parameter int DEPTH     = 4,
  parameter int KEY_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         scan_ready,
  input  logic [7:0]                   scan_code,
  output logic [KEY_WIDTH-1:0]         key,
  output logic                         caps_lock,
  output logic [$clog2(DEPTH+1)-1:0]   held_count,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t      state, state_next;
  logic        rdy_d;
  logic        accept;
  logic        mk, brk, ext;
  logic        shift_l, shift_r, caps_held;
  logic [8:0]  stk      [DEPTH];
  logic [8:0]  stk_next [DEPTH];
  logic [CW-1:0] cnt, cnt_next;
  logic        evict, evict_p0;
  logic [8:0]  entry, top;
  logic        mapped, present, hit;
  logic [7:0]  key_code;

  // Lower-case ASCII for letter keys, 0 for anything else.
  function automatic logic [7:0] letter(input logic [7:0] code);
    logic [7:0] r;
    case (code)
      8'h1C: r = 8'd97;  8'h32: r = 8'd98;  8'h21: r = 8'd99;  8'h23: r = 8'd100;
      8'h24: r = 8'd101; 8'h2B: r = 8'd102; 8'h34: r = 8'd103; 8'h33: r = 8'd104;
      8'h43: r = 8'd105; 8'h3B: r = 8'd106; 8'h42: r = 8'd107; 8'h4B: r = 8'd108;
      8'h3A: r = 8'd109; 8'h31: r = 8'd110; 8'h44: r = 8'd111; 8'h4D: r = 8'd112;
      8'h15: r = 8'd113; 8'h2D: r = 8'd114; 8'h1B: r = 8'd115; 8'h2C: r = 8'd116;
      8'h3C: r = 8'd117; 8'h2A: r = 8'd118; 8'h1D: r = 8'd119; 8'h22: r = 8'd120;
      8'h35: r = 8'd121; 8'h1A: r = 8'd122;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  // Hack key code for {ext, code}; 0 means unmapped (modifiers included).
  function automatic logic [7:0] xlate(input logic e, input logic [7:0] code,
                                       input logic shift, input logic caps);
    logic [7:0] lc, lo, hi, r;
    lc = letter(code);
    lo = 8'd0;
    hi = 8'd0;
    case ({e, code})
      9'h016: begin lo = 8'd49;  hi = 8'd33;  end
      9'h01E: begin lo = 8'd50;  hi = 8'd64;  end
      9'h026: begin lo = 8'd51;  hi = 8'd35;  end
      9'h025: begin lo = 8'd52;  hi = 8'd36;  end
      9'h02E: begin lo = 8'd53;  hi = 8'd37;  end
      9'h036: begin lo = 8'd54;  hi = 8'd94;  end
      9'h03D: begin lo = 8'd55;  hi = 8'd38;  end
      9'h03E: begin lo = 8'd56;  hi = 8'd42;  end
      9'h046: begin lo = 8'd57;  hi = 8'd40;  end
      9'h045: begin lo = 8'd48;  hi = 8'd41;  end
      9'h00E: begin lo = 8'd96;  hi = 8'd126; end
      9'h04E: begin lo = 8'd45;  hi = 8'd95;  end
      9'h055: begin lo = 8'd61;  hi = 8'd43;  end
      9'h054: begin lo = 8'd91;  hi = 8'd123; end
      9'h05B: begin lo = 8'd93;  hi = 8'd125; end
      9'h05D: begin lo = 8'd92;  hi = 8'd124; end
      9'h04C: begin lo = 8'd59;  hi = 8'd58;  end
      9'h052: begin lo = 8'd39;  hi = 8'd34;  end
      9'h041: begin lo = 8'd44;  hi = 8'd60;  end
      9'h049: begin lo = 8'd46;  hi = 8'd62;  end
      9'h04A: begin lo = 8'd47;  hi = 8'd63;  end
      9'h029: begin lo = 8'd32;  hi = 8'd32;  end
      9'h05A, 9'h15A: begin lo = 8'd128; hi = 8'd128; end
      9'h066: begin lo = 8'd129; hi = 8'd129; end
      9'h076: begin lo = 8'd140; hi = 8'd140; end
      9'h005: begin lo = 8'd141; hi = 8'd141; end
      9'h006: begin lo = 8'd142; hi = 8'd142; end
      9'h004: begin lo = 8'd143; hi = 8'd143; end
      9'h00C: begin lo = 8'd144; hi = 8'd144; end
      9'h003: begin lo = 8'd145; hi = 8'd145; end
      9'h00B: begin lo = 8'd146; hi = 8'd146; end
      9'h083: begin lo = 8'd147; hi = 8'd147; end
      9'h00A: begin lo = 8'd148; hi = 8'd148; end
      9'h001: begin lo = 8'd149; hi = 8'd149; end
      9'h009: begin lo = 8'd150; hi = 8'd150; end
      9'h078: begin lo = 8'd151; hi = 8'd151; end
      9'h007: begin lo = 8'd152; hi = 8'd152; end
      9'h16B: begin lo = 8'd130; hi = 8'd130; end
      9'h175: begin lo = 8'd131; hi = 8'd131; end
      9'h174: begin lo = 8'd132; hi = 8'd132; end
      9'h172: begin lo = 8'd133; hi = 8'd133; end
      9'h16C: begin lo = 8'd134; hi = 8'd134; end
      9'h169: begin lo = 8'd135; hi = 8'd135; end
      9'h17D: begin lo = 8'd136; hi = 8'd136; end
      9'h17A: begin lo = 8'd137; hi = 8'd137; end
      9'h170: begin lo = 8'd138; hi = 8'd138; end
      9'h171: begin lo = 8'd139; hi = 8'd139; end
      9'h14A: begin lo = 8'd47;  hi = 8'd47;  end
      // Keypad without E0: digits and operators, shift has no effect.
      9'h070: begin lo = 8'd48;  hi = 8'd48;  end
      9'h069: begin lo = 8'd49;  hi = 8'd49;  end
      9'h072: begin lo = 8'd50;  hi = 8'd50;  end
      9'h07A: begin lo = 8'd51;  hi = 8'd51;  end
      9'h06B: begin lo = 8'd52;  hi = 8'd52;  end
      9'h073: begin lo = 8'd53;  hi = 8'd53;  end
      9'h074: begin lo = 8'd54;  hi = 8'd54;  end
      9'h06C: begin lo = 8'd55;  hi = 8'd55;  end
      9'h075: begin lo = 8'd56;  hi = 8'd56;  end
      9'h07D: begin lo = 8'd57;  hi = 8'd57;  end
      9'h071: begin lo = 8'd46;  hi = 8'd46;  end
      9'h07C: begin lo = 8'd42;  hi = 8'd42;  end
      9'h07B: begin lo = 8'd45;  hi = 8'd45;  end
      9'h079: begin lo = 8'd43;  hi = 8'd43;  end
      default: begin lo = 8'd0; hi = 8'd0; end
    endcase
    if (!e && lc != 8'd0)
      r = (shift ^ caps) ? (lc - 8'd32) : lc;
    else
      r = shift ? hi : lo;
    return r;
  endfunction

  assign accept = scan_ready & ~rdy_d;
  assign entry  = {ext, scan_code};
  assign mapped = (xlate(ext, scan_code, 1'b0, 1'b0) != 8'd0);

  always_comb begin
    state_next = state;
    mk  = 1'b0;
    brk = 1'b0;
    ext = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (scan_code == 8'hF0)      state_next = BRK;
          else if (scan_code == 8'hE0) state_next = EXT;
          else                         mk = 1'b1;
        end
        EXT: begin
          if (scan_code == 8'hF0) state_next = EXT_BRK;
          else begin
            mk = 1'b1;
            ext = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          brk = 1'b1;
          state_next = IDLE;
        end
        EXT_BRK: begin
          brk = 1'b1;
          ext = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Stack update: typematic makes and unmatched breaks fall through unchanged.
  always_comb begin
    stk_next = stk;
    cnt_next = cnt;
    evict    = 1'b0;
    present  = 1'b0;
    hit      = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < cnt && stk[i] == entry) present = 1'b1;
    if (mk && mapped && !present) begin
      if (cnt == CW'(DEPTH)) begin
        for (int i = 0; i < DEPTH-1; i++) stk_next[i] = stk[i+1];
        stk_next[DEPTH-1] = entry;
        evict = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == cnt) stk_next[i] = entry;
        cnt_next = cnt + 1'b1;
      end
    end
    if (brk && mapped && present) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        if (CW'(i) < cnt && stk[i] == entry) hit = 1'b1;
        if (hit) stk_next[i] = stk[i+1];
      end
      stk_next[DEPTH-1] = '0;
      cnt_next = cnt - 1'b1;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i + 1) == cnt) top = stk[i];
    key_code = (cnt != '0) ? xlate(top[8], top[7:0], shift_l | shift_r, caps_lock) : 8'd0;
  end

  // Stage p0: prefix FSM, modifiers and stack update on the accepting edge.
  always_ff @(posedge clk) begin
    rdy_d <= scan_ready;
    if (reset) begin
      state     <= IDLE;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
      cnt       <= '0;
      evict_p0  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      state    <= state_next;
      stk      <= stk_next;
      cnt      <= cnt_next;
      evict_p0 <= evict;
      if ((mk || brk) && !ext) begin
        if (scan_code == 8'h12) shift_l <= mk;
        if (scan_code == 8'h59) shift_r <= mk;
        if (scan_code == 8'h58) begin
          caps_held <= mk;
          if (mk && !caps_held) caps_lock <= ~caps_lock;
        end
      end
    end
  end

  // Stage p1: registered outputs, one cycle after the state update.
  always_ff @(posedge clk) begin
    if (reset) begin
      key        <= '0;
      held_count <= '0;
      overflow   <= 1'b0;
    end else begin
      key        <= KEY_WIDTH'(key_code);
      held_count <= cnt;
      overflow   <= evict_p0;
    end
  end

endmodule

// File: tb/tb_hack_keyboard.sv
// Directed bench for hack_keyboard: make/break, modifiers, stack, E0 codes, reset.
module tb_hack_keyboard;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan_ready = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic [15:0] key;
  logic        caps_lock;
  logic [2:0]  held_count;
  logic        overflow;
  int errors = 0;
  int checks = 0;

  hack_keyboard #(.DEPTH(4), .KEY_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code),
    .key(key), .caps_lock(caps_lock), .held_count(held_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Returns on the falling edge after the output-update edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code = b;
    scan_ready = 1'b1;
    @(negedge clk);
    scan_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (key !== 16'd0 || caps_lock !== 1'b0 || held_count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: key=%0d caps=%0d held=%0d ovf=%0d, want all 0",
               key, caps_lock, held_count, overflow);
    end
  endtask

  task automatic test_make_break;
    @(negedge clk);
    scan_code = 8'h1C;
    scan_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (key !== 16'd0) begin
      errors++; $display("FAIL latency_one_cycle: key=%0d want 0", key);
    end
    scan_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (key !== 16'd97 || held_count !== 3'd1) begin
      errors++; $display("FAIL make_a: key=%0d held=%0d want 97/1", key, held_count);
    end
    send(8'hF0);
    checks++;
    if (key !== 16'd97) begin
      errors++; $display("FAIL prefix_f0: key=%0d want 97", key);
    end
    send(8'h1C);
    checks++;
    if (key !== 16'd0 || held_count !== 3'd0) begin
      errors++; $display("FAIL break_a: key=%0d held=%0d want 0/0", key, held_count);
    end
  endtask

  task automatic test_caps_shift;
    send(8'h58); send(8'hF0); send(8'h58);
    checks++;
    if (caps_lock !== 1'b1) begin
      errors++; $display("FAIL caps_on: caps=%0d want 1", caps_lock);
    end
    send(8'h32);
    checks++;
    if (key !== 16'd66) begin
      errors++; $display("FAIL caps_b: key=%0d want 66", key);
    end
    send(8'h12);
    checks++;
    if (key !== 16'd98 || held_count !== 3'd1) begin
      errors++; $display("FAIL shift_caps_b: key=%0d held=%0d want 98/1", key, held_count);
    end
    send(8'hF0); send(8'h12);
    checks++;
    if (key !== 16'd66) begin
      errors++; $display("FAIL shift_release: key=%0d want 66", key);
    end
    send(8'hF0); send(8'h32);
    // Typematic caps repeats toggle only once.
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    checks++;
    if (caps_lock !== 1'b0) begin
      errors++; $display("FAIL caps_typematic: caps=%0d want 0", caps_lock);
    end
    send(8'h16);
    checks++;
    if (key !== 16'd49) begin
      errors++; $display("FAIL digit_1: key=%0d want 49", key);
    end
    send(8'h59);
    checks++;
    if (key !== 16'd33) begin
      errors++; $display("FAIL rshift_1: key=%0d want 33", key);
    end
    send(8'hF0); send(8'h59); send(8'hF0); send(8'h16);
    checks++;
    if (key !== 16'd0 || held_count !== 3'd0) begin
      errors++; $display("FAIL digit_release: key=%0d held=%0d want 0/0", key, held_count);
    end
  endtask

  task automatic test_stack;
    send(8'h23); send(8'h24);
    checks++;
    if (key !== 16'd101 || held_count !== 3'd2) begin
      errors++; $display("FAIL two_held: key=%0d held=%0d want 101/2", key, held_count);
    end
    send(8'hF0); send(8'h24);
    checks++;
    if (key !== 16'd100) begin
      errors++; $display("FAIL release_top: key=%0d want 100", key);
    end
    send(8'h23); send(8'h23);
    checks++;
    if (held_count !== 3'd1 || key !== 16'd100) begin
      errors++; $display("FAIL typematic: held=%0d key=%0d want 1/100", held_count, key);
    end
    send(8'hF0); send(8'h23);
    checks++;
    if (key !== 16'd0 || held_count !== 3'd0) begin
      errors++; $display("FAIL release_all: key=%0d held=%0d want 0/0", key, held_count);
    end
    send(8'hF0); send(8'h1C);
    checks++;
    if (held_count !== 3'd0 || key !== 16'd0) begin
      errors++; $display("FAIL stray_break: held=%0d key=%0d want 0/0", held_count, key);
    end
  endtask

  task automatic test_overflow;
    int pulses;
    logic [7:0] seq [5];
    seq = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      send(seq[i]);
      if (overflow === 1'b1) pulses++;
    end
    @(negedge clk);
    checks++;
    if (pulses != 1 || held_count !== 3'd4 || key !== 16'd101 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow: pulses=%0d held=%0d key=%0d ovf_now=%0d want 1/4/101/0",
               pulses, held_count, key, overflow);
    end
    send(8'hF0); send(8'h1C);
    checks++;
    if (held_count !== 3'd4 || key !== 16'd101) begin
      errors++; $display("FAIL evicted_break: held=%0d key=%0d want 4/101", held_count, key);
    end
    send(8'hF0); send(8'h21);
    checks++;
    if (held_count !== 3'd3 || key !== 16'd101) begin
      errors++; $display("FAIL middle_break: held=%0d key=%0d want 3/101", held_count, key);
    end
    send(8'hF0); send(8'h24);
    checks++;
    if (key !== 16'd100) begin
      errors++; $display("FAIL compact_top: key=%0d want 100", key);
    end
    send(8'hF0); send(8'h23);
    checks++;
    if (key !== 16'd98 || held_count !== 3'd1) begin
      errors++; $display("FAIL bottom_left: key=%0d held=%0d want 98/1", key, held_count);
    end
    send(8'hF0); send(8'h32);
  endtask

  task automatic test_extended;
    send(8'hE0); send(8'h75);
    checks++;
    if (key !== 16'd131) begin
      errors++; $display("FAIL ext_up: key=%0d want 131", key);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++;
    if (key !== 16'd0 || held_count !== 3'd0) begin
      errors++; $display("FAIL ext_break: key=%0d held=%0d want 0/0", key, held_count);
    end
    send(8'h75);
    checks++;
    if (key !== 16'd56) begin
      errors++; $display("FAIL keypad_8: key=%0d want 56", key);
    end
    send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12); send(8'h1C);
    checks++;
    if (key !== 16'd97) begin
      errors++; $display("FAIL fake_shift: key=%0d want 97", key);
    end
    send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h12);
    send(8'h03);
    checks++;
    if (key !== 16'd145) begin
      errors++; $display("FAIL f5: key=%0d want 145", key);
    end
    send(8'hE0); send(8'h5A);
    checks++;
    if (key !== 16'd128 || held_count !== 3'd2) begin
      errors++; $display("FAIL kp_enter: key=%0d held=%0d want 128/2", key, held_count);
    end
    send(8'hE0); send(8'hF0); send(8'h5A); send(8'hF0); send(8'h03);
    checks++;
    if (key !== 16'd0 || held_count !== 3'd0) begin
      errors++; $display("FAIL ext_cleanup: key=%0d held=%0d want 0/0", key, held_count);
    end
  endtask

  task automatic test_reset_mid;
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    checks++;
    if (key !== 16'd65 || caps_lock !== 1'b1) begin
      errors++; $display("FAIL pre_reset: key=%0d caps=%0d want 65/1", key, caps_lock);
    end
    @(negedge clk);
    scan_code = 8'hF0;
    scan_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (key !== 16'd0 || caps_lock !== 1'b0 || held_count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: key=%0d caps=%0d held=%0d ovf=%0d want all 0",
               key, caps_lock, held_count, overflow);
    end
    scan_ready = 1'b0;
    @(negedge clk);
    send(8'h1C);
    checks++;
    if (key !== 16'd97 || held_count !== 3'd1) begin
      errors++; $display("FAIL after_reset: key=%0d held=%0d want 97/1", key, held_count);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_caps_shift();
    test_stack();
    test_overflow();
    test_extended();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
